dense_layer_seq: RTL and testbench
==================================

Name: dense_layer_seq

Overview:
- Parametrised fully-connected layer: NUM_NEURONS parallel signed MAC lanes fed by a streamed input vector of IN_COUNT samples, one sample per beat.
- Each beat carries one input sample plus the matching weight column, one weight per neuron.
- After the last beat the block adds a per-neuron bias, applies the selected activation, and presents all outputs on a valid/ready handshake.
- Sits between a sample/weight streamer (memory reader) and the next layer or argmax stage.

Parameters:
- IN_COUNT, 784, input samples per inference (>=2).
- NUM_NEURONS, 10, neuron lanes (>=1).
- DATA_W, 9, signed input sample width.
- WEIGHT_W, 16, signed weight width.
- BIAS_W, 16, signed bias width.
- ACC_W, 48, signed accumulator width (>= DATA_W+WEIGHT_W+$clog2(IN_COUNT)+1).
- OUT_W, 32, signed output width per neuron (<= ACC_W).

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins an inference in IDLE.
- act_sel  in  1  activation select, sampled on accepted start: 0 identity, 1 ReLU.
- in_valid  in  1  sample beat valid.
- in_ready  out  1  block accepts a beat.
- in_data  in  DATA_W  signed sample.
- w_data  in  NUM_NEURONS*WEIGHT_W  weight column; lane i at [i*WEIGHT_W +: WEIGHT_W].
- bias  in  NUM_NEURONS*BIAS_W  per-neuron biases; must be stable from start until out_valid.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts.
- out_data  out  NUM_NEURONS*OUT_W  results; lane i at [i*OUT_W +: OUT_W].
- beat_count  out  $clog2(IN_COUNT)  beats accepted in the current inference.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse after the output handshake.

Behaviour:
- Reset (asynchronous, rstn low): state IDLE; accumulators 0; in_ready 0, out_valid 0, out_data 0, beat_count 0, busy 0, done 0; latched act_sel 0. Reset mid-inference aborts it with no done pulse.
- States: IDLE -> ACCUM -> BIAS -> OUTPUT -> IDLE.
- IDLE:
  - start=1 latches act_sel, clears all accumulators and beat_count, and moves to ACCUM.
  - start is ignored in every other state.
- ACCUM:
  - in_ready=1.
  - Each beat with in_valid&in_ready: acc[i] += sext(in_data)*sext(w_data lane i), full signed product sign-extended to ACC_W; beat_count increments.
  - No beat accepted means accumulators hold.
  - The beat accepted at beat_count==IN_COUNT-1 moves to BIAS, with in_ready low from the next cycle. beat_count returns to 0 on entering BIAS.
- BIAS: one cycle, in_ready=0.
  - Per lane: s = acc[i] + sext(bias lane i).
  - If latched act_sel=1 and s<0, then s=0.
  - s is reduced to OUT_W (see Optional Feature) and registered into out_data; out_valid=1 next cycle; state moves to OUTPUT.
- OUTPUT:
  - out_data and out_valid hold stable until out_ready.
  - On out_valid&out_ready: out_valid 0, done 1 for exactly that next cycle, state IDLE.
  - out_data retains its last value after the handshake.
- Latency: with continuous in_valid, out_valid rises IN_COUNT+1 cycles after the first accepted beat.
- Back-to-back inferences: a start in the cycle done is high is accepted.
- A simultaneous start and handshake in OUTPUT ignores the start.

Optional Feature:
- Macro DENSE_LAYER_SAT_EN.
- Defined: results outside the signed OUT_W range clamp to 2^(OUT_W-1)-1 or -2^(OUT_W-1).
- Undefined: results truncate to the low OUT_W bits (two's-complement wrap), saving comparators.
- Accumulation is never saturated in either build.

Test Plan:
- IN_COUNT=4, NUM_NEURONS=2, act_sel=0; samples 1,2,3,4; lane0 weights all 1, lane1 weights all -2; bias 5,0 -> out_data lane0=15, lane1=-20; out_valid 5 cycles after first beat.
- Same stimulus with act_sel=1 -> lane0=15, lane1=0.
- in_valid toggled every other cycle and out_ready held low 10 cycles -> same results; out_data stable while stalled; done single pulse after the handshake.
- DENSE_LAYER_SAT_EN build, OUT_W=8: sample 127, weight 127 for 4 beats, bias 0 -> lane=127 (saturated); without the macro -> low 8 bits of 64516 = 4.
- rstn asserted after beat 2 -> all outputs 0 immediately, no done. A fresh start then gives a correct result with no residue.
- start pulsed during ACCUM and OUTPUT -> ignored; beat_count sequence 0,1,2,3 then 0.

Source files
------------

// File: rtl/dense_layer_seq.sv
// dense_layer_seq: streamed fully-connected layer with NUM_NEURONS signed MAC lanes, bias and identity/ReLU.
// Define DENSE_LAYER_SAT_EN to clamp results to OUT_W instead of wrapping to the low OUT_W bits.
module dense_layer_seq #(
    parameter int IN_COUNT    = 784,
    parameter int NUM_NEURONS = 10,
    parameter int DATA_W      = 9,
    parameter int WEIGHT_W    = 16,
    parameter int BIAS_W      = 16,
    parameter int ACC_W       = 48,
    parameter int OUT_W       = 32
) (
    input  logic                            clk,
    input  logic                            rstn,
    input  logic                            start,
    input  logic                            act_sel,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [DATA_W-1:0]               in_data,
    input  logic [NUM_NEURONS*WEIGHT_W-1:0] w_data,
    input  logic [NUM_NEURONS*BIAS_W-1:0]   bias,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [NUM_NEURONS*OUT_W-1:0]    out_data,
    output logic [$clog2(IN_COUNT)-1:0]     beat_count,
    output logic                            busy,
    output logic                            done
);
    localparam int CW = $clog2(IN_COUNT);
    localparam int PW = DATA_W + WEIGHT_W;
    localparam int SW = ACC_W + 1;

    typedef enum logic [1:0] {IDLE, ACCUM, BIAS, OUTPUT} state_t;
    state_t state, state_nxt;
    logic act_q, take, beat, last_beat;
    logic [NUM_NEURONS*OUT_W-1:0] res;

    assign in_ready  = state == ACCUM;
    assign out_valid = state == OUTPUT;
    assign busy      = state != IDLE;
    assign take      = state == IDLE && start;
    assign beat      = in_valid && in_ready;
    assign last_beat = beat && beat_count == CW'(IN_COUNT - 1);

    always_ff @(posedge clk or negedge rstn)
        if (!rstn) state <= IDLE;
        else state <= state_nxt;

    always_comb
        state_nxt = take ? ACCUM : last_beat ? BIAS : state == BIAS ? OUTPUT :
                    (out_valid && out_ready) ? IDLE : state;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            act_q      <= 1'b0;
            beat_count <= '0;
            done       <= 1'b0;
            out_data   <= '0;
        end else begin
            done       <= out_valid && out_ready;
            act_q      <= take ? act_sel : act_q;
            beat_count <= (take || last_beat) ? '0 : beat ? beat_count + CW'(1) : beat_count;
            if (state == BIAS) out_data <= res;
        end
    end

    for (genvar i = 0; i < NUM_NEURONS; i++) begin : g_lane
        logic [ACC_W-1:0] acc;
        logic [WEIGHT_W-1:0] w;
        logic [BIAS_W-1:0] b;
        logic [PW-1:0] prod;
        logic [SW-1:0] s, r;
        assign w    = w_data[i*WEIGHT_W +: WEIGHT_W];
        assign b    = bias[i*BIAS_W +: BIAS_W];
        // Low PW bits of an unsigned product of sign-extended operands equal the signed product.
        assign prod = {{WEIGHT_W{in_data[DATA_W-1]}}, in_data} * {{DATA_W{w[WEIGHT_W-1]}}, w};
        assign s    = {acc[ACC_W-1], acc} + {{(SW-BIAS_W){b[BIAS_W-1]}}, b};
        assign r    = (act_q && s[SW-1]) ? '0 : s;

        always_ff @(posedge clk or negedge rstn)
            if (!rstn) acc <= '0;
            else if (take) acc <= '0;
            else if (beat) acc <= acc + {{(ACC_W-PW){prod[PW-1]}}, prod};

`ifdef DENSE_LAYER_SAT_EN
        logic [SW-1:OUT_W-1] hi;
        assign hi = r[SW-1:OUT_W-1];
        assign res[i*OUT_W +: OUT_W] = (&hi || ~|hi) ? r[OUT_W-1:0]
                                                     : {r[SW-1], {(OUT_W-1){~r[SW-1]}}};
`else
        logic unused_hi;
        assign unused_hi = ^r;
        assign res[i*OUT_W +: OUT_W] = r[OUT_W-1:0];
`endif
    end
endmodule

// File: tb/tb_dense_layer_seq.sv
// tb_dense_layer_seq: directed bench for dense_layer_seq with a plain-arithmetic reference model.
module tb_dense_layer_seq;
    localparam int IC = 4;
    localparam int NN = 2;
    localparam int OW = 8;

    logic clk = 1'b0;
    logic rstn = 1'b1;
    logic start = 1'b0, act_sel = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [8:0] in_data = '0;
    logic [NN*16-1:0] w_data = '0;
    logic [NN*16-1:0] bias = '0;
    logic in_ready, out_valid, busy, done;
    logic [NN*OW-1:0] out_data;
    logic [1:0] beat_count;

    int errors = 0, checks = 0, cyc = 0;
    int samp[IC];
    int wt[NN][IC];
    int bv[NN];
    longint exp_q[NN];
    bit hs_prev = 1'b0;

    dense_layer_seq #(.IN_COUNT(IC), .NUM_NEURONS(NN), .DATA_W(9), .WEIGHT_W(16),
                      .BIAS_W(16), .ACC_W(48), .OUT_W(OW)) dut (
        .clk(clk), .rstn(rstn), .start(start), .act_sel(act_sel), .in_valid(in_valid),
        .in_ready(in_ready), .in_data(in_data), .w_data(w_data), .bias(bias),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .beat_count(beat_count), .busy(busy), .done(done));

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic longint lane_out(input int l);
        logic signed [OW-1:0] v;
        v = out_data[l*OW +: OW];
        return v;
    endfunction

    function automatic longint reduce(input longint s);
        longint mx = (64'sd1 <<< (OW-1)) - 1;
`ifdef DENSE_LAYER_SAT_EN
        return s > mx ? mx : s < -mx-1 ? -mx-1 : s;
`else
        longint m = s & ((64'sd1 <<< OW) - 1);
        return m > mx ? m - (64'sd1 <<< OW) : m;
`endif
    endfunction

    function automatic longint model(input int l, input bit act);
        longint s = bv[l];
        for (int b = 0; b < IC; b++) s += longint'(samp[b]) * wt[l][b];
        if (act && s < 0) s = 0;
        return reduce(s);
    endfunction

    always @(negedge clk) begin
        if (!rstn) hs_prev = 1'b0;
        else begin
            check("done_pulse", done, hs_prev);
            if (out_valid)
                for (int l = 0; l < NN; l++) check("out_lane", lane_out(l), exp_q[l]);
            hs_prev = out_valid && out_ready;
        end
    end

    task automatic check_zero(input string tag);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_data"}, out_data, 0);
        check({tag, "_beat_count"}, beat_count, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
    endtask

    task automatic drive_beat(input int b);
        in_valid = 1'b1;
        in_data  = 9'(samp[b]);
        for (int l = 0; l < NN; l++) w_data[l*16 +: 16] = 16'(wt[l][b]);
    endtask

    task automatic run(input bit act, input int gap, input int stall, input bit poke);
        int t0 = 0, n = 0;
        for (int l = 0; l < NN; l++) begin
            exp_q[l] = model(l, act);
            bias[l*16 +: 16] = 16'(bv[l]);
        end
        start = 1'b1;
        act_sel = act;
        @(posedge clk); #1;
        start = 1'b0;
        act_sel = ~act;
        for (int b = 0; b < IC; b++) begin
            start = 1'b0;
            in_valid = 1'b0;
            for (int g = 0; g < gap; g++) begin @(posedge clk); #1; end
            drive_beat(b);
            start = poke && b == 1;
            if (b == 0) t0 = cyc;
            check("beat_count", beat_count, b);
            check("in_ready", in_ready, 1);
            check("busy", busy, 1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        start = 1'b0;
        check("in_ready_bias", in_ready, 0);
        check("beat_count_bias", beat_count, 0);
        while (!out_valid && n < 30) begin @(posedge clk); #1; n++; end
        check("out_valid_seen", out_valid, 1);
        if (gap == 0) check("latency", cyc - t0, IC + 1);
        for (int s = 0; s < stall; s++) begin
            start = poke && s == 0;
            @(posedge clk); #1;
            start = 1'b0;
            check("stall_valid", out_valid, 1);
        end
        start = poke;
        out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        out_ready = 1'b0;
        check("done_after_hs", done, 1);
        check("valid_drop", out_valid, 0);
        check("busy_idle", busy, 0);
        for (int l = 0; l < NN; l++) check("retain", lane_out(l), exp_q[l]);
    endtask

    task automatic load_basic();
        samp = '{1, 2, 3, 4};
        wt   = '{'{1, 1, 1, 1}, '{-2, -2, -2, -2}};
        bv   = '{5, 0};
    endtask

    initial begin
        #1 rstn = 1'b0;
        #2 check_zero("reset");
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;

        load_basic();
        run(1'b0, 0, 0, 1'b0);
        check("lit_id_lane0", lane_out(0), 15);
        check("lit_id_lane1", lane_out(1), -20);

        run(1'b1, 0, 0, 1'b0);
        check("lit_relu_lane0", lane_out(0), 15);
        check("lit_relu_lane1", lane_out(1), 0);

        run(1'b0, 1, 10, 1'b1);
        check("lit_stall_lane0", lane_out(0), 15);
        check("lit_stall_lane1", lane_out(1), -20);

        samp = '{127, 127, 127, 127};
        wt   = '{'{127, 127, 127, 127}, '{-127, -127, -127, -127}};
        bv   = '{0, 0};
        run(1'b0, 0, 2, 1'b0);
`ifdef DENSE_LAYER_SAT_EN
        check("lit_sat_lane0", lane_out(0), 127);
        check("lit_sat_lane1", lane_out(1), -128);
`else
        check("lit_wrap_lane0", lane_out(0), 4);
        check("lit_wrap_lane1", lane_out(1), -4);
`endif

        samp = '{-3, 100, -256, 255};
        wt   = '{'{7, -8, 2, 1}, '{-1, 1, 0, -1}};
        bv   = '{-7, 300};
        run(1'b0, 0, 1, 1'b0);
        run(1'b1, 1, 0, 1'b1);

        load_basic();
        bv = '{9, -1};
        for (int l = 0; l < NN; l++) bias[l*16 +: 16] = 16'(bv[l]);
        start = 1'b1;
        act_sel = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        for (int b = 0; b < 2; b++) begin
            drive_beat(b);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rstn = 1'b0;
        #1 check_zero("abort");
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        check("abort_no_done", done, 0);

        load_basic();
        run(1'b0, 0, 0, 1'b0);
        check("lit_fresh_lane0", lane_out(0), 15);
        check("lit_fresh_lane1", lane_out(1), -20);

        repeat (3) @(posedge clk);
        #1 $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end
endmodule
